nand_gate_rr_arbiter: RTL and testbench

Shares one registered NAND datapath among NUM_REQ requesters using a round-robin arbiter.
- Each requester presents an operand pair under a valid/ready handshake.
- The granted pair is NANDed and held in a single-entry output register, tagged with the requester index.
- The output side drives the nand_gate_out bus (y) with a valid/ready handshake toward the consumer.

---
 rtl/nand_gate_rr_arbiter.sv | 92 +++++++++
 tb/tb_nand_gate_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_rr_arbiter.sv
// Round-robin arbiter sharing one registered NAND stage among NUM_REQ requesters; result on y one cycle after accept.
// Backpressure: while y is held and y_ready is low no requester is granted; drain and refill overlap for one result per cycle.
module nand_gate_rr_arbiter #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           y,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [ID_W-1:0]            y_id,
    output logic [15:0]                grant_cnt
);

    localparam int CW = ID_W + 1;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  nxt_ptr;
    logic [CW-1:0]    cand;
    logic             found;
    logic             can_accept;
    logic             accept;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
            assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign can_accept = !y_valid || y_ready;
    assign accept     = found && can_accept;
    assign nxt_ptr    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    // Walk indices rr_ptr, rr_ptr+1, ... wrapping; first valid one wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) begin
            req_ready[win] = can_accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            y_valid   <= 1'b0;
            y_id      <= '0;
            grant_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                y       <= ~(a_arr[win] & b_arr[win]);
                y_id    <= win;
                y_valid <= 1'b1;
                rr_ptr  <= nxt_ptr;
                if (grant_cnt != 16'hFFFF) begin
                    grant_cnt <= grant_cnt + 16'd1;
                end
            end else if (y_ready) begin
                // Drain only: y and y_id keep their last values.
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nand_gate_rr_arbiter.sv
// Directed bench: stimulus pushes expected results into a scoreboard, a negedge monitor pops on each y handshake.
module tb_nand_gate_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_id;
    logic [15:0] grant_cnt;

    logic [7:0] a_t [4];
    logic [7:0] b_t [4];
    logic [7:0] exp_y [4];

    typedef struct {
        logic [7:0] y;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   sb_en     = 1'b1;

    assign req_a = {a_t[3], a_t[2], a_t[1], a_t[0]};
    assign req_b = {b_t[3], b_t[2], b_t[1], b_t[0]};

    nand_gate_rr_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_id      (y_id),
        .grant_cnt (grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.y  = exp_y[id];
        e.id = 2'(id);
        sb.push_back(e);
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (!rst && sb_en && y_valid && y_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got y=%0h id=%0d expected no output", y, y_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_y", 32'(y), 32'(e.y));
                chk("sb_id", 32'(y_id), 32'(e.id));
            end
        end
    end

    initial begin
        // Hand-computed NAND results per requester.
        a_t[0] = 8'hFF; b_t[0] = 8'h0F; exp_y[0] = 8'hF0;
        a_t[1] = 8'hAA; b_t[1] = 8'h55; exp_y[1] = 8'hFF;
        a_t[2] = 8'hF0; b_t[2] = 8'h3C; exp_y[2] = 8'hCF;
        a_t[3] = 8'h12; b_t[3] = 8'h34; exp_y[3] = 8'hEF;
        rst = 1'b1; req_valid = '0; y_ready = 1'b0;
        #8;
        chk("rst_y", 32'(y), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_grant_cnt", 32'(grant_cnt), 0);
        step();
        rst = 1'b0;
        step();

        // Single request from requester 2.
        y_ready = 1'b1; req_valid = 4'b0100;
        #1; chk("single_req_ready", 32'(req_ready), 32'b0100);
        push(2);
        step();
        req_valid = '0;
        chk("single_y", 32'(y), 32'hCF);
        chk("single_y_id", 32'(y_id), 2);
        chk("single_y_valid", 32'(y_valid), 1);

        // Pointer now 3: with 0 and 3 valid, 3 wins.
        req_valid = 4'b1001;
        #1; chk("ptr3_req_ready", 32'(req_ready), 32'b1000);
        push(3);
        step();

        // Full round robin, one grant per cycle.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1; chk("rr_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            push(k % 4);
            step();
        end
        req_valid = '0;
        chk("rr_grant_cnt", 32'(grant_cnt), 10);
        step();
        chk("drain_y_valid", 32'(y_valid), 0);
        chk("drain_y_hold", 32'(y), 32'hEF);
        chk("drain_id_hold", 32'(y_id), 3);

        // Wrap: move pointer to 3, then 0 and 1 both pending.
        req_valid = 4'b0100; push(2); step();
        req_valid = 4'b0011;
        #1; chk("wrap_first", 32'(req_ready), 32'b0001);
        push(0); step();
        #1; chk("wrap_second", 32'(req_ready), 32'b0010);
        push(1); step();
        req_valid = '0; step();

        // Backpressure: hold result from 0 while 1 waits.
        y_ready = 1'b0; req_valid = 4'b0001;
        push(0); step();
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_y", 32'(y), 32'hF0);
            chk("bp_y_id", 32'(y_id), 0);
            step();
        end
        y_ready = 1'b1;
        #1; chk("bp_release_ready", 32'(req_ready), 32'b0010);
        push(1); step();
        req_valid = '0;
        chk("bp_new_y", 32'(y), 32'hFF);
        chk("bp_new_id", 32'(y_id), 1);
        step();

        // Asynchronous reset mid-cycle while a result is held.
        y_ready = 1'b0; req_valid = 4'b0001; step();
        req_valid = '0;
        chk("pre_rst_valid", 32'(y_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_y", 32'(y), 0);
        chk("async_rst_valid", 32'(y_valid), 0);
        chk("async_rst_id", 32'(y_id), 0);
        chk("async_rst_cnt", 32'(grant_cnt), 0);
        step();
        rst = 1'b0;
        step();

        // Saturation of the accept counter.
        sb_en = 1'b0; y_ready = 1'b1; req_valid = 4'b1111;
        for (int k = 0; k < 65534; k++) step();
        chk("sat_fffe", 32'(grant_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) step();
        chk("sat_ffff", 32'(grant_cnt), 32'hFFFF);
        req_valid = '0;
        step(); step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
